// File: rtl/i_type_sequencer.sv
// i_type_sequencer: multi-cycle control FSM for the I-type datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> WB, handles the imem/dmem
// handshakes, traps illegal instructions and ack timeouts, counts retirements.
module i_type_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ir,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_rw,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_ctrl,
    output logic             illegal_instr,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned ALU_W  = 4;

    // Last wait-counter value before the increment would reach the limit.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_n;
    logic [ALU_W-1:0]    dec_alu_q;
    logic [ALU_W-1:0]    dec_alu_n;
    logic                dec_lw_q;
    logic                dec_lw_n;
    logic                illegal_n;
    logic                bus_err_n;
    logic [CNT_W-1:0]    retired_n;

    logic                imem_req_n;
    logic                dmem_req_n;
    logic                dmem_rw_n;
    logic                pc_we_n;
    logic                reg_write_n;
    logic                mem_to_reg_n;
    logic                alu_src_n;
    logic [ALU_W-1:0]    alu_ctrl_n;
    logic                halted_n;
    logic                hold_n;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                dec_legal;
    logic [ALU_W-1:0]    dec_alu;
    logic                dec_lw;

    // Only opcode and funct3 take part in control decode.
    logic                unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign unused_ir_bits = ^{ir[31:15], ir[11:7]};

    // The one combinational output: IR load strobe follows the fetch ack.
    assign ir_we = imem_req & imem_ack;

    // Instruction decode: legality, ALU op select and load flag.
    always_comb begin
        dec_legal = 1'b0;
        dec_alu   = '0;
        dec_lw    = 1'b0;
        case (opcode)
            OP_IMM: begin
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = 4'b0000; end
                    3'b111: begin dec_legal = 1'b1; dec_alu = 4'b0010; end
                    3'b110: begin dec_legal = 1'b1; dec_alu = 4'b0100; end
                    3'b001: begin dec_legal = 1'b1; dec_alu = 4'b1000; end
                    3'b101: begin dec_legal = 1'b1; dec_alu = 4'b0011; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_alu   = 4'b0000;
                    dec_lw    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next state, wait counter, sticky flags, and next values of the output registers.
    always_comb begin
        state_n   = state_q;
        wait_n    = '0;
        dec_alu_n = dec_alu_q;
        dec_lw_n  = dec_lw_q;
        illegal_n = illegal_instr;
        bus_err_n = bus_err;
        retired_n = retired;

        case (state_q)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_n = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_n   = TRAP;
                    bus_err_n = 1'b1;
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    state_n   = EXECUTE;
                    dec_alu_n = dec_alu;
                    dec_lw_n  = dec_lw;
                end else begin
                    state_n   = TRAP;
                    illegal_n = 1'b1;
                end
            end
            EXECUTE: begin
                state_n = dec_lw_q ? MEM : WB;
            end
            MEM: begin
                if (dmem_ack) begin
                    state_n = WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_n   = TRAP;
                    bus_err_n = 1'b1;
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                state_n   = FETCH;
                retired_n = retired + CNT_W'(1);
            end
            TRAP: begin
                state_n = TRAP;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered as a pure decode of the next state.
        hold_n       = (state_n == EXECUTE) || (state_n == MEM) || (state_n == WB);
        imem_req_n   = (state_n == FETCH);
        dmem_req_n   = (state_n == MEM);
        dmem_rw_n    = (state_n == MEM);
        pc_we_n      = (state_n == WB);
        reg_write_n  = (state_n == WB);
        alu_src_n    = hold_n;
        alu_ctrl_n   = hold_n ? dec_alu_n : '0;
        mem_to_reg_n = hold_n & dec_lw_n;
        halted_n     = (state_n == TRAP);
    end

    // State, decode fields, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            dec_alu_q     <= '0;
            dec_lw_q      <= 1'b0;
            illegal_instr <= 1'b0;
            bus_err       <= 1'b0;
            retired       <= '0;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_rw       <= 1'b0;
            pc_we         <= 1'b0;
            reg_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src       <= 1'b0;
            alu_ctrl      <= '0;
            halted        <= 1'b0;
        end else begin
            state_q       <= state_n;
            wait_q        <= wait_n;
            dec_alu_q     <= dec_alu_n;
            dec_lw_q      <= dec_lw_n;
            illegal_instr <= illegal_n;
            bus_err       <= bus_err_n;
            retired       <= retired_n;
            imem_req      <= imem_req_n;
            dmem_req      <= dmem_req_n;
            dmem_rw       <= dmem_rw_n;
            pc_we         <= pc_we_n;
            reg_write     <= reg_write_n;
            mem_to_reg    <= mem_to_reg_n;
            alu_src       <= alu_src_n;
            alu_ctrl      <= alu_ctrl_n;
            halted        <= halted_n;
        end
    end

endmodule

// File: tb/tb_i_type_sequencer.sv
// Bench for i_type_sequencer: per-instruction driver/monitor plus a writeback scoreboard.
module tb_i_type_sequencer;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_REG  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_rw;
    logic        ir_we;
    logic        pc_we;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        illegal_instr;
    logic        bus_err;
    logic        halted;
    logic [31:0] retired;

    i_type_sequencer #(.TIMEOUT_CYCLES(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_rw(dmem_rw), .ir_we(ir_we),
        .pc_we(pc_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr), .bus_err(bus_err),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Writeback record: alu_ctrl, mem_to_reg, alu_src, pc_we, cycle index within the instruction.
    typedef struct packed {
        logic [3:0] alu;
        logic       m2r;
        logic       src;
        logic       pcwe;
        logic [7:0] cyc;
    } wb_t;

    wb_t exp_q[$];
    wb_t obs_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the last run_instr call.
    int         c;
    int         irwe_cyc;
    int         irwe_cnt;
    int         dreq_cnt;
    int         drw_cnt;
    int         halt_cyc;
    int         berr_cyc;
    int         exec_cyc;
    logic [3:0] exec_alu;
    logic       exec_m2r;
    logic       saw_rw;
    logic       saw_pcwe;
    logic       timed_out;

    function automatic logic [31:0] mk_i(input logic [6:0] op, input logic [2:0] f3);
        return {12'h008, 5'd1, f3, 5'd3, op};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from its FETCH cycle until WB or TRAP; iwait/dwait = -1 withholds the ack.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait, input bit spur);
        int  icnt;
        int  dcnt;
        bit  done;
        icnt = 0; dcnt = 0; done = 0;
        c = 0; irwe_cyc = 0; irwe_cnt = 0; dreq_cnt = 0; drw_cnt = 0; halt_cyc = 0; berr_cyc = 0;
        exec_cyc = 0; exec_alu = '0; exec_m2r = 1'b0; saw_rw = 1'b0; saw_pcwe = 1'b0; timed_out = 1'b0;
        ir = instr;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
            imem_ack = imem_req ? (iwait >= 0 && icnt == iwait) : spur;
            dmem_ack = dmem_req ? (dwait >= 0 && dcnt == dwait) : spur;
            if (imem_req) icnt++;
            if (dmem_req) dcnt++;
            #1;
            if (ir_we) begin irwe_cnt++; if (irwe_cyc == 0) irwe_cyc = c; end
            if (dmem_req) dreq_cnt++;
            if (dmem_rw) drw_cnt++;
            if (bus_err && berr_cyc == 0) berr_cyc = c;
            if (alu_src && exec_cyc == 0) begin exec_cyc = c; exec_alu = alu_ctrl; exec_m2r = mem_to_reg; end
            if (pc_we) saw_pcwe = 1'b1;
            if (reg_write) begin
                saw_rw = 1'b1;
                obs_q.push_back({alu_ctrl, mem_to_reg, alu_src, pc_we, 8'(c)});
                done = 1;
            end
            if (halted) begin halt_cyc = c; done = 1; end
        end
        if (!done) timed_out = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'b1; dmem_ack = 1'b1;
            #1;
            n_tests++;
            if ({imem_req, dmem_req, dmem_rw, ir_we, pc_we, reg_write, mem_to_reg, alu_src, alu_ctrl,
                 illegal_instr, bus_err, halted} !== 15'd0 || retired !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got req=%b dreq=%b irwe=%b alu=%h halted=%b retired=%0d want all 0",
                         imem_req, dmem_req, ir_we, alu_ctrl, halted, retired);
            end
        end
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_fetch: got imem_req=%b want 1", imem_req); end
    endtask

    task automatic test_addi();
        wb_t e, o;
        do_reset();
        exp_q.push_back({4'b0000, 1'b0, 1'b1, 1'b1, 8'd4});
        run_instr(32'h00500093, 0, 0, 0);
        n_tests++;
        if (irwe_cyc !== 1) begin n_fail++; $display("FAIL addi_irwe_cycle: got %0d want 1", irwe_cyc); end
        n_tests++;
        if ({exec_cyc, exec_alu, exec_m2r} !== {32'd3, 4'b0000, 1'b0}) begin
            n_fail++; $display("FAIL addi_execute: got cyc=%0d alu=%b m2r=%b want cyc=3 alu=0000 m2r=0", exec_cyc, exec_alu, exec_m2r);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL addi_wb: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL addi_wb: got %h want %h", o, e); end
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (retired !== 32'd1) begin n_fail++; $display("FAIL addi_retired: got %0d want 1", retired); end
    endtask

    task automatic test_lw();
        wb_t e, o;
        exp_q.push_back({4'b0000, 1'b1, 1'b1, 1'b1, 8'd8});
        run_instr(32'h0080A103, 0, 3, 0);
        n_tests++;
        if (dreq_cnt !== 4 || drw_cnt !== 4) begin
            n_fail++; $display("FAIL lw_dmem_req_cycles: got req=%0d rw=%0d want 4/4", dreq_cnt, drw_cnt);
        end
        n_tests++;
        if ({exec_cyc, exec_m2r} !== {32'd3, 1'b1}) begin
            n_fail++; $display("FAIL lw_execute: got cyc=%0d m2r=%b want 3/1", exec_cyc, exec_m2r);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL lw_wb: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL lw_wb: got %h want %h", o, e); end
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (retired !== 32'd2) begin n_fail++; $display("FAIL lw_retired: got %0d want 2", retired); end
    endtask

    task automatic test_back_to_back();
        wb_t e, o;
        logic [2:0] f3s  [4];
        logic [3:0] alus [4];
        int total;
        f3s  = '{3'b111, 3'b110, 3'b001, 3'b101};
        alus = '{4'b0010, 4'b0100, 4'b1000, 4'b0011};
        total = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({alus[k], 1'b0, 1'b1, 1'b1, 8'd4});
            run_instr(mk_i(OP_IMM, f3s[k]), 0, 0, 0);
            total += c;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_wb%0d: got none want %h", k, e); end
                else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin n_fail++; $display("FAIL b2b_wb%0d: got %h want %h", k, o, e); end
                end
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (retired !== 32'd4 || total !== 16) begin
            n_fail++; $display("FAIL b2b_retired: got retired=%0d cycles=%0d want 4/16", retired, total);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad = '{mk_i(OP_IMM, 3'b010), mk_i(OP_LOAD, 3'b000), mk_i(OP_REG, 3'b000)};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            run_instr(bad[k], 0, 0, 0);
            n_tests++;
            if (halt_cyc !== 3 || {illegal_instr, bus_err} !== 2'b10) begin
                n_fail++; $display("FAIL illegal%0d_trap: got halt_cyc=%0d ill=%b berr=%b want 3/1/0", k, halt_cyc, illegal_instr, bus_err);
            end
            n_tests++;
            if (saw_rw !== 1'b0 || saw_pcwe !== 1'b0 || obs_q.size() !== 0) begin
                n_fail++; $display("FAIL illegal%0d_no_wb: got rw=%b pcwe=%b wbs=%0d want 0/0/0", k, saw_rw, saw_pcwe, obs_q.size());
            end
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                imem_ack = 1'b1;
                #1;
                n_tests++;
                if ({imem_req, ir_we, pc_we, reg_write, halted, illegal_instr} !== 6'b000011) begin
                    n_fail++; $display("FAIL illegal%0d_hold: got req=%b irwe=%b pcwe=%b rw=%b halt=%b ill=%b want 000011",
                                       k, imem_req, ir_we, pc_we, reg_write, halted, illegal_instr);
                end
            end
            imem_ack = 1'b0;
            obs_q.delete();
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({illegal_instr, bus_err, halted} !== 3'b000) begin
            n_fail++; $display("FAIL illegal_reset_clear: got ill=%b berr=%b halt=%b want 000", illegal_instr, bus_err, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        wb_t e, o;
        // Fetch ack withheld: 15 wait cycles then TRAP.
        do_reset();
        run_instr(32'h00500093, -1, 0, 0);
        n_tests++;
        if (halt_cyc !== 16 || berr_cyc !== 16 || {bus_err, illegal_instr} !== 2'b10 || irwe_cnt !== 0) begin
            n_fail++; $display("FAIL timeout_fetch: got halt=%0d berr_cyc=%0d berr=%b ill=%b irwe=%0d want 16/16/1/0/0",
                               halt_cyc, berr_cyc, bus_err, illegal_instr, irwe_cnt);
        end
        // Fetch ack on the 15th request cycle wins.
        do_reset();
        exp_q.push_back({4'b0000, 1'b0, 1'b1, 1'b1, 8'd18});
        run_instr(32'h00500093, 14, 0, 0);
        n_tests++;
        if (irwe_cyc !== 15 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fetch_edge: got irwe_cyc=%0d berr=%b want 15/0", irwe_cyc, bus_err);
        end
        // Data ack withheld.
        do_reset();
        run_instr(32'h0080A103, 0, -1, 0);
        n_tests++;
        if (halt_cyc !== 19 || bus_err !== 1'b1 || saw_rw !== 1'b0) begin
            n_fail++; $display("FAIL timeout_mem: got halt=%0d berr=%b rw=%b want 19/1/0", halt_cyc, bus_err, saw_rw);
        end
        // Data ack on the 15th request cycle wins.
        do_reset();
        exp_q.push_back({4'b0000, 1'b1, 1'b1, 1'b1, 8'd19});
        run_instr(32'h0080A103, 0, 14, 0);
        n_tests++;
        if (dreq_cnt !== 15 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_mem_edge: got dreq=%0d berr=%b want 15/0", dreq_cnt, bus_err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL timeout_wb: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL timeout_wb: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_spurious();
        wb_t e, o;
        do_reset();
        exp_q.push_back({4'b0000, 1'b0, 1'b1, 1'b1, 8'd4});
        run_instr(32'h00500093, 0, 0, 1);
        n_tests++;
        if (irwe_cnt !== 1) begin n_fail++; $display("FAIL spurious_irwe: got %0d want 1", irwe_cnt); end
        exp_q.push_back({4'b0000, 1'b1, 1'b1, 1'b1, 8'd6});
        run_instr(32'h0080A103, 0, 1, 1);
        n_tests++;
        if (irwe_cnt !== 1 || dreq_cnt !== 2) begin
            n_fail++; $display("FAIL spurious_lw: got irwe=%0d dreq=%0d want 1/2", irwe_cnt, dreq_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL spurious_wb: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL spurious_wb: got %h want %h", o, e); end
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (retired !== 32'd2) begin n_fail++; $display("FAIL spurious_retired: got %0d want 2", retired); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_instr(32'h00500093, 0, 0, 0);
        obs_q.delete();
        ir = 32'h0080A103;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            imem_ack = (i == 1);
            dmem_ack = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midreset_in_mem: got dmem_req=%b want 1", dmem_req); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({imem_req, dmem_req, dmem_rw, pc_we, reg_write, mem_to_reg, alu_src, alu_ctrl,
                 illegal_instr, bus_err, halted} !== 14'd0 || retired !== 32'd0) begin
                n_fail++; $display("FAIL midreset_outputs: got dreq=%b alu_src=%b alu=%b retired=%0d want 0",
                                   dmem_req, alu_src, alu_ctrl, retired);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got imem_req=%b want 0", imem_req); end
        @(posedge clk); #1;
        n_tests++;
        if (imem_req !== 1'b1 || retired !== 32'd0) begin
            n_fail++; $display("FAIL midreset_fetch: got imem_req=%b retired=%0d want 1/0", imem_req, retired);
        end
    endtask

    initial begin
        rst_n = 1'b0; ir = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
        test_reset();
        test_addi();
        test_lw();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_spurious();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
